alu_display_scan: RTL and testbench

ALU_DISPLAY_SCAN -- requirements
Module: alu_display_scan

---
 rtl/alu_display_scan.sv | 145 ++++++++++++++
 tb/tb_alu_display_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_display_scan.sv
// Two-digit seven-segment scanner for an ALU result: captures a result on load,
// multiplexes tens/units digits, and blinks "Er" while the error flag is captured.
module alu_display_scan #(
    parameter int SCAN_DIV  = 1024,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] dec_bin,
    input  logic [3:0] unis_bin,
    input  logic       zero,
    input  logic       error,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       zero_led,
    output logic       load_ack
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    localparam logic [6:0] GLYPH_DASH = 7'h40;
    localparam logic [6:0] GLYPH_E    = 7'h79;
    localparam logic [6:0] GLYPH_R    = 7'h50;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        ERR
    } state_t;

    state_t        state;
    logic [SW-1:0] slot_cnt;
    logic          sel;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic          zero_c;
    logic          err_c;

    logic          slot_wrap;
    logic [6:0]    seg_p0;
    logic [1:0]    an_p0;
    logic          zero_p0;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'h3F;
            4'd1:    g = 7'h06;
            4'd2:    g = 7'h5B;
            4'd3:    g = 7'h4F;
            4'd4:    g = 7'h66;
            4'd5:    g = 7'h6D;
            4'd6:    g = 7'h7D;
            4'd7:    g = 7'h07;
            4'd8:    g = 7'h7F;
            4'd9:    g = 7'h6F;
            default: g = GLYPH_DASH;
        endcase
        return g;
    endfunction

    assign slot_wrap = (slot_cnt == SLOT_LAST);

    // Stage p0: decode the current state into the next display drive
    always_comb begin
        seg_p0 = '0;
        an_p0  = '0;
        case (state)
            SHOW: begin
                if (sel) begin
                    an_p0  = 2'b10;
                    seg_p0 = (tens == 4'd0) ? 7'h00 : glyph(tens);
                end else begin
                    an_p0  = 2'b01;
                    seg_p0 = glyph(units);
                end
            end
            ERR: begin
                if (blink_on) begin
                    an_p0  = sel ? 2'b10 : 2'b01;
                    seg_p0 = sel ? GLYPH_E : GLYPH_R;
                end
            end
            default: ;
        endcase
        zero_p0 = (state != IDLE) && zero_c && !err_c;
    end

    // Stage p1: registered state, capture and display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            slot_cnt  <= '0;
            sel       <= 1'b0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            tens      <= '0;
            units     <= '0;
            zero_c    <= 1'b0;
            err_c     <= 1'b0;
            seg       <= '0;
            an        <= '0;
            zero_led  <= 1'b0;
            load_ack  <= 1'b0;
        end else begin
            load_ack <= load;

            if (slot_wrap) begin
                slot_cnt <= '0;
                sel      <= ~sel;
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end

            // A capture always restarts blinking in the ON phase
            if (load) begin
                tens      <= dec_bin;
                units     <= unis_bin;
                zero_c    <= zero;
                err_c     <= error;
                state     <= error ? ERR : SHOW;
                blink_cnt <= '0;
                blink_on  <= 1'b1;
            end else if (state == ERR && slot_wrap) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end

            seg      <= seg_p0;
            an       <= an_p0;
            zero_led <= zero_p0;
        end
    end

endmodule

// File: tb/tb_alu_display_scan.sv
// Scoreboard bench for alu_display_scan: a cycle-count based reference model pushes
// expected outputs per clock edge; they are popped and compared just after the edge.
module tb_alu_display_scan;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] dec_bin;
    logic [3:0] unis_bin;
    logic       zero;
    logic       error;
    logic [6:0] seg;
    logic [1:0] an;
    logic       zero_led;
    logic       load_ack;

    alu_display_scan #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .dec_bin  (dec_bin),
        .unis_bin (unis_bin),
        .zero     (zero),
        .error    (error),
        .seg      (seg),
        .an       (an),
        .zero_led (zero_led),
        .load_ack (load_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [1:0] an;
        logic       zl;
        logic       ack;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [6:0] gly[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    // Reference model: 0=IDLE 1=SHOW 2=ERR; edges counted since reset release
    int         m_state;
    int         m_k;
    int         m_wraps;
    logic [3:0] m_d;
    logic [3:0] m_u;
    logic       m_z;
    logic       m_e;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] req);
        n_tests++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, req, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_k = 0; m_wraps = 0;
        m_d = '0; m_u = '0; m_z = 1'b0; m_e = 1'b0;
        sb.delete();
    endtask

    function automatic exp_t model_out(input logic ld);
        exp_t x;
        logic s;
        logic on;
        x = '0;
        s  = ((m_k / SCAN_DIV) % 2) == 1;
        on = ((m_wraps / BLINK_DIV) % 2) == 0;
        if (m_state == 1) begin
            x.an  = s ? 2'b10 : 2'b01;
            x.seg = s ? ((m_d == 4'd0) ? 7'h00 : gly[m_d]) : gly[m_u];
        end else if (m_state == 2 && on) begin
            x.an  = s ? 2'b10 : 2'b01;
            x.seg = s ? 7'h79 : 7'h50;
        end
        x.zl  = (m_state != 0) && m_z && !m_e;
        x.ack = ld;
        return x;
    endfunction

    // One clock: drive inputs now (just after an edge), predict at the edge, compare 1 time unit later
    task automatic step(input logic ld, input logic [3:0] d, input logic [3:0] u,
                        input logic z, input logic e);
        exp_t x;
        logic wrap;
        load = ld; dec_bin = d; unis_bin = u; zero = z; error = e;
        @(posedge clk);
        sb.push_back(model_out(ld));
        m_k++;
        wrap = (m_k % SCAN_DIV) == 0;
        if (ld) begin
            m_d = d; m_u = u; m_z = z; m_e = e;
            m_state = e ? 2 : 1;
            m_wraps = 0;
        end else if (m_state == 2 && wrap) begin
            m_wraps++;
        end
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 8'd1, 8'd0);
        end else begin
            x = sb.pop_front();
            check("seg", {1'b0, seg}, {1'b0, x.seg});
            check("an", {6'd0, an}, {6'd0, x.an});
            check("zero_led", {7'd0, zero_led}, {7'd0, x.zl});
            check("load_ack", {7'd0, load_ack}, {7'd0, x.ack});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic async_reset_check(input string tag);
        #3 rst_n = 1'b0;
        load = 1'b0;
        #1;
        check({tag, "_seg"}, {1'b0, seg}, 8'h00);
        check({tag, "_an"}, {6'd0, an}, 8'h00);
        check({tag, "_zl"}, {7'd0, zero_led}, 8'h00);
        check({tag, "_ack"}, {7'd0, load_ack}, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n = 1'b1;
        load = 1'b0; dec_bin = '0; unis_bin = '0; zero = 1'b0; error = 1'b0;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg", {1'b0, seg}, 8'h00);
        check("rst_an", {6'd0, an}, 8'h00);
        check("rst_zl", {7'd0, zero_led}, 8'h00);
        check("rst_ack", {7'd0, load_ack}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        idle(20);

        step(1'b1, 4'd4, 4'd2, 1'b0, 1'b0);
        idle(16);

        step(1'b1, 4'd0, 4'd0, 1'b1, 1'b0);
        idle(16);

        // Error blink, then a second error load mid-blink restarts the ON phase
        step(1'b1, 4'd9, 4'd9, 1'b0, 1'b1);
        idle(37);
        step(1'b1, 4'd1, 4'd1, 1'b1, 1'b1);
        idle(20);

        // Out-of-range digits, back-to-back loads (last wins), then a load on the slot-wrap edge
        step(1'b1, 4'd3, 4'd3, 1'b0, 1'b0);
        step(1'b1, 4'd12, 4'd15, 1'b0, 1'b0);
        idle(9);
        while (((m_k + 1) % SCAN_DIV) != 0) idle(1);
        step(1'b1, 4'd7, 4'd3, 1'b0, 1'b0);
        idle(10);

        step(1'b1, 4'd5, 4'd6, 1'b0, 1'b1);
        idle(11);
        async_reset_check("async");
        idle(12);
        step(1'b1, 4'd1, 4'd5, 1'b0, 1'b0);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
